// File: rtl/kp_pkg.sv
// Shared types, key map and frame helpers for the 4x4 matrix keypad scanner.
package kp_pkg;

  localparam int unsigned KP_ROWS   = 4;
  localparam int unsigned KP_COLS   = 4;
  localparam int unsigned KP_KEYS   = KP_ROWS * KP_COLS;
  localparam int unsigned KP_CODE_W = 4;
  localparam int unsigned KP_POP_W  = 5;

  // One bit per key, bit index = row*4 + col, 1 = pressed.
  typedef logic [KP_KEYS-1:0] kp_frame_t;

  typedef logic [1:0] kp_state_t;
  localparam kp_state_t S_IDLE  = 2'd0;
  localparam kp_state_t S_PRESS = 2'd1;
  localparam kp_state_t S_MULTI = 2'd2;

  typedef enum logic [1:0] {
    KP_NONE = 2'd0,
    KP_ONE  = 2'd1,
    KP_MANY = 2'd2
  } kp_class_t;

  // Rows r0..r3 read "1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D"; entry 0 is r0,c0.
  localparam logic [KP_KEYS-1:0][KP_CODE_W-1:0] KP_CODE_LUT = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [KP_POP_W-1:0] kp_popcount(input kp_frame_t v);
    logic [KP_POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < KP_KEYS; i++) begin
      n = n + KP_POP_W'(v[i]);
    end
    return n;
  endfunction

  // Position of the lowest set bit; only meaningful for one-hot frames.
  function automatic logic [KP_CODE_W-1:0] kp_onehot_index(input kp_frame_t v);
    logic [KP_CODE_W-1:0] idx;
    idx = '0;
    for (int i = KP_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = KP_CODE_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic kp_class_t kp_classify(input kp_frame_t v);
    logic [KP_POP_W-1:0] n;
    n = kp_popcount(v);
    if (n == KP_POP_W'(0)) begin
      return KP_NONE;
    end else if (n == KP_POP_W'(1)) begin
      return KP_ONE;
    end
    return KP_MANY;
  endfunction

endpackage

// File: rtl/kp_debounce.sv
// Whole-frame debouncer: accepts a raw frame once it has repeated for
// DEBOUNCE_FRAMES consecutive scans, strobing deb_upd for one cycle.
module kp_debounce
  import kp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      frame_done,
  input  kp_frame_t frame,
  output kp_frame_t deb,
  output logic      deb_upd
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_FRAMES - 1);

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_deb_range_chk
    $error("kp_debounce: DEBOUNCE_FRAMES must be in 1..15");
  end

  kp_frame_t        prev;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] stable_nxt;
  logic             accept;

  // Saturating repeat count, and acceptance of a changed, settled frame.
  always_comb begin
    stable_nxt = '0;
    if (frame == prev) begin
      stable_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + CNT_W'(1);
    end
    accept = frame_done && (stable_nxt >= CNT_ACCEPT) && (frame != deb);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev       <= '0;
      stable_cnt <= '0;
      deb        <= '0;
      deb_upd    <= 1'b0;
    end else begin
      deb_upd <= accept;
      if (frame_done) begin
        prev       <= frame;
        stable_cnt <= stable_nxt;
      end
      if (accept) begin
        deb <= frame;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, row synchronisation and sampling,
// frame debouncing and one key event per clean single-key press.
module keypad_scanner
  import kp_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
  parameter int unsigned SCAN_RATE_HZ    = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_multi
);

  localparam int unsigned COL_DIV = CLK_FREQ_HZ / (SCAN_RATE_HZ * KP_COLS);
  localparam int unsigned COL_MAX = COL_DIV - 1;
  localparam int unsigned TICK_W  = (COL_DIV > 4) ? $clog2(COL_DIV) : 2;

  if (COL_DIV < 4) begin : g_col_max_chk
    $error("keypad_scanner: COL_MAX must be >= 3");
  end

  logic [TICK_W-1:0] tick;
  logic [1:0]        col_cnt;
  logic              col_tick;
  logic              frame_done;
  logic [3:0]        row_meta;
  logic [3:0]        row_sync;
  logic [3:0]        row_hit;
  kp_frame_t         raw_acc;
  kp_frame_t         row_spread;
  kp_frame_t         frame;
  kp_frame_t         deb;
  logic              deb_upd;
  kp_class_t         deb_cls;

  kp_state_t         state;
  kp_state_t         state_nxt;
  logic [3:0]        code_nxt;
  logic              valid_nxt;
  logic              down_nxt;
  logic              multi_nxt;

  assign col_tick   = (tick == TICK_W'(COL_MAX));
  assign frame_done = col_tick && (col_cnt == 2'd3);

  // Column strobe timing; kp_col tracks col_cnt so exactly one column is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick    <= '0;
      col_cnt <= 2'd0;
      kp_col  <= 4'b1110;
    end else if (col_tick) begin
      tick    <= '0;
      col_cnt <= col_cnt + 2'd1;
      kp_col  <= ~(4'b0001 << (col_cnt + 2'd1));
    end else begin
      tick    <= tick + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp_row;
      row_sync <= row_meta;
    end
  end

  // Current column's rows dropped into bits row*4+col of the frame under construction.
  assign row_hit    = ~row_sync;
  assign row_spread = {3'b000, row_hit[3], 3'b000, row_hit[2],
                       3'b000, row_hit[1], 3'b000, row_hit[0]};
  assign frame      = (raw_acc & ~(16'h1111 << col_cnt)) | (row_spread << col_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_acc <= '0;
    end else if (col_tick) begin
      raw_acc <= frame;
    end
  end

  kp_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_done(frame_done),
    .frame     (frame),
    .deb       (deb),
    .deb_upd   (deb_upd)
  );

  assign deb_cls = kp_classify(deb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Press FSM: only a single key reached from full release produces an event.
  always_comb begin
    state_nxt = state;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    if (deb_upd) begin
      case (state)
        S_IDLE: begin
          if (deb_cls == KP_ONE) begin
            state_nxt = S_PRESS;
            code_nxt  = KP_CODE_LUT[kp_onehot_index(deb)];
            valid_nxt = 1'b1;
          end else if (deb_cls == KP_MANY) begin
            state_nxt = S_MULTI;
          end
        end
        S_PRESS: begin
          state_nxt = (deb_cls == KP_NONE) ? S_IDLE : S_MULTI;
        end
        S_MULTI: begin
          if (deb_cls == KP_NONE) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
    down_nxt  = (state_nxt == S_PRESS);
    multi_nxt = (state_nxt == S_MULTI);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      key_multi <= 1'b0;
    end else begin
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_down  <= down_nxt;
      key_multi <= multi_nxt;
    end
  end

endmodule
